mix_columns_ctrl: RTL and testbench

- Sequential controller that applies the AES MixColumns transform to a full 128-bit state.
- Time-multiplexes the existing combinational mixColumn row-slice, which produces one output byte from four column bytes and a 2-bit row select, across all 16 (column, row) positions.
- Sits between ShiftRows and AddRoundKey in the round datapath, driven by the round sequencer through a start/done handshake.

---
 rtl/aes_mix_pkg.sv | 46 ++++
 rtl/mixColumn.sv | 43 ++++
 rtl/mix_columns_ctrl.sv | 172 +++++++++++++++++
 tb/tb_mix_columns_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/aes_mix_pkg.sv
// Shared types and byte-indexing helpers for the MixColumns controller.
//
// Contents:
//   byte_t, state_t  - byte and 128-bit AES state types
//   mc_state_e       - controller FSM states {IDLE, RUN, DONE}
//   NB               - number of columns (and rows) in the AES state
//   get_byte()       - read byte idx (0..15, column-major) from a state
//   set_byte()       - return a copy of a state with byte idx replaced
//
// Byte idx = 4*col + row. With msb_first=1 byte 0 sits at [127:120],
// otherwise at [7:0].
package aes_mix_pkg;

    typedef logic [7:0]   byte_t;
    typedef logic [127:0] state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mc_state_e;

    localparam int unsigned NB = 4;

    // Bit position of the least significant bit of byte idx.
    function automatic int unsigned byte_lsb(input logic [3:0] idx, input logic msb_first);
        if (msb_first) begin
            return 8 * (15 - 32'(idx));
        end
        return 8 * 32'(idx);
    endfunction

    function automatic byte_t get_byte(input state_t s, input logic [3:0] idx,
                                       input logic msb_first);
        return s[byte_lsb(idx, msb_first) +: 8];
    endfunction

    function automatic state_t set_byte(input state_t s, input logic [3:0] idx,
                                        input byte_t b, input logic msb_first);
        state_t r;
        r = s;
        r[byte_lsb(idx, msb_first) +: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/mixColumn.sv
// Combinational MixColumns row slice.
//
// Produces one output byte of a mixed column from the four input column
// bytes and a row select, using the FIPS-197 matrix over GF(2^8) with
// reduction polynomial 0x11B:
//   out[row] = 2*a[row] ^ 3*a[row+1] ^ a[row+2] ^ a[row+3]   (indices mod 4)
//
// Ports:
//   col_in0..col_in3  in  8  column bytes, row 0..3
//   row               in  2  output row select
//   col_out           out 8  mixed byte for the selected row
module mixColumn (
    input  logic [7:0] col_in0,
    input  logic [7:0] col_in1,
    input  logic [7:0] col_in2,
    input  logic [7:0] col_in3,
    input  logic [1:0] row,
    output logic [7:0] col_out
);

    // Multiply by x in GF(2^8), poly 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] a [4];
    logic [1:0] r1;
    logic [1:0] r2;
    logic [1:0] r3;

    always_comb begin
        a[0] = col_in0;
        a[1] = col_in1;
        a[2] = col_in2;
        a[3] = col_in3;
        // 2-bit adds wrap mod 4, giving the circulant matrix rotation.
        r1 = row + 2'd1;
        r2 = row + 2'd2;
        r3 = row + 2'd3;
        col_out = xtime(a[row]) ^ xtime(a[r1]) ^ a[r1] ^ a[r2] ^ a[r3];
    end

endmodule

// File: rtl/mix_columns_ctrl.sv
// Sequential AES MixColumns controller.
//
// Applies MixColumns to a 128-bit state by time-multiplexing the mixColumn
// row slice over all (column, row) byte positions. Start/done handshake
// toward the round sequencer; the result is held on state_o until the next
// accepted operation completes.
//
// Build option: define MIX_COLUMNS_PAR4_EN to instantiate four mixColumn
// slices (one per row) and finish a whole column per cycle (4 RUN cycles
// instead of 16). Handshake, reset and hold behaviour are unchanged.
//
// Parameters:
//   BYTE_ORDER_MSB_FIRST  1: byte 0 at [127:120] (FIPS-197); 0: byte 0 at [7:0]
//
// Ports:
//   clk      in  1    system clock, rising edge
//   rst_n    in  1    asynchronous active-low reset
//   start_i  in  1    request, sampled only while ready_o=1
//   state_i  in  128  input state, captured on accepted start
//   ready_o  out 1    high in IDLE and DONE
//   busy_o   out 1    high in RUN
//   done_o   out 1    one-cycle pulse when state_o becomes valid
//   state_o  out 128  MixColumns result
module mix_columns_ctrl #(
    parameter int BYTE_ORDER_MSB_FIRST = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [127:0] state_i,
    output logic         ready_o,
    output logic         busy_o,
    output logic         done_o,
    output logic [127:0] state_o
);

    import aes_mix_pkg::*;

    localparam logic MSB_FIRST = (BYTE_ORDER_MSB_FIRST != 0);

    mc_state_e  state_q;
    logic [1:0] col_q;
    state_t     src_q;
    state_t     res_q;
    state_t     out_q;
    logic       ready_q;
    logic       busy_q;
    logic       done_q;

    state_t     res_next;
    logic       last_step;
    byte_t      col_in [NB];

    // Current source column, rows 0..3.
    always_comb begin
        for (int unsigned i = 0; i < NB; i++) begin
            col_in[i] = get_byte(src_q, {col_q, 2'(i)}, MSB_FIRST);
        end
    end

`ifdef MIX_COLUMNS_PAR4_EN

    byte_t mix_out [NB];

    for (genvar r = 0; r < 4; r++) begin : g_mix
        mixColumn u_mix (
            .col_in0 (col_in[0]),
            .col_in1 (col_in[1]),
            .col_in2 (col_in[2]),
            .col_in3 (col_in[3]),
            .row     (2'(r)),
            .col_out (mix_out[r])
        );
    end

    always_comb begin
        res_next = res_q;
        for (int unsigned r = 0; r < NB; r++) begin
            res_next = set_byte(res_next, {col_q, 2'(r)}, mix_out[r], MSB_FIRST);
        end
        last_step = (col_q == 2'd3);
    end

`else

    logic [1:0] row_q;
    byte_t      mix_out;

    mixColumn u_mix (
        .col_in0 (col_in[0]),
        .col_in1 (col_in[1]),
        .col_in2 (col_in[2]),
        .col_in3 (col_in[3]),
        .row     (row_q),
        .col_out (mix_out)
    );

    always_comb begin
        res_next  = set_byte(res_q, {col_q, row_q}, mix_out, MSB_FIRST);
        last_step = (col_q == 2'd3) && (row_q == 2'd3);
    end

`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= 2'd0;
`ifndef MIX_COLUMNS_PAR4_EN
            row_q   <= 2'd0;
`endif
            src_q   <= '0;
            res_q   <= '0;
            out_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                // DONE accepts a new start exactly like IDLE (no bubble).
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        src_q   <= state_i;
                        col_q   <= 2'd0;
`ifndef MIX_COLUMNS_PAR4_EN
                        row_q   <= 2'd0;
`endif
                        state_q <= RUN;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                RUN: begin
                    res_q <= res_next;
`ifdef MIX_COLUMNS_PAR4_EN
                    col_q <= col_q + 2'd1;
`else
                    row_q <= row_q + 2'd1;
                    if (row_q == 2'd3) begin
                        col_q <= col_q + 2'd1;
                    end
`endif
                    if (last_step) begin
                        // res_next already holds the final byte(s) written this cycle.
                        out_q   <= res_next;
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o = ready_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign state_o = out_q;

endmodule

// File: tb/tb_mix_columns_ctrl.sv
// Directed self-checking bench for mix_columns_ctrl (both build options).
module tb_mix_columns_ctrl;

`ifdef MIX_COLUMNS_PAR4_EN
    localparam int LAT    = 5;
    localparam int MID    = 2;
    localparam int RST_AT = 3;
`else
    localparam int LAT    = 17;
    localparam int MID    = 5;
    localparam int RST_AT = 8;
`endif

    localparam logic [127:0] VEC_A = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] EXP_A = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    localparam logic [127:0] VEC_B = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] EXP_B = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;

    logic         clk;
    logic         rst_n;
    logic         start_i;
    logic [127:0] state_i;
    logic         ready_o;
    logic         busy_o;
    logic         done_o;
    logic [127:0] state_o;

    int n_checks;
    int n_fail;

    mix_columns_ctrl #(
        .BYTE_ORDER_MSB_FIRST (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_i),
        .state_i (state_i),
        .ready_o (ready_o),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .state_o (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge: presents a one-cycle start; returns 1 ns after edge 0.
    task automatic start_op(input logic [127:0] v);
        state_i = v;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        start_i = 1'b0;
        state_i = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done_o); end
        n_checks++; if (state_o !== 128'h0) begin n_fail++; $display("FAIL reset_state: got %h want 0", state_o); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fips();
        start_op(VEC_A);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            n_checks++;
            if (busy_o !== 1'(k < LAT)) begin
                n_fail++; $display("FAIL fips_busy c%0d: got %b want %b", k, busy_o, k < LAT);
            end
            n_checks++;
            if (done_o !== 1'(k == LAT)) begin
                n_fail++; $display("FAIL fips_done c%0d: got %b want %b", k, done_o, k == LAT);
            end
            if (k < LAT) begin
                n_checks++;
                if (state_o !== 128'h0) begin
                    n_fail++; $display("FAIL fips_partial c%0d: got %h want 0", k, state_o);
                end
            end
        end
        n_checks++; if (state_o !== EXP_A) begin n_fail++; $display("FAIL fips_result: got %h want %h", state_o, EXP_A); end
        @(negedge clk);
        n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL fips_pulse: got %b want 0", done_o); end
        n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL fips_ready: got %b want 1", ready_o); end
    endtask

    task automatic test_back_to_back();
        state_i = VEC_A;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        state_i = VEC_B;
        for (int k = 1; k <= 2 * LAT; k++) begin
            @(negedge clk);
            n_checks++;
            if (done_o !== 1'(k == LAT || k == 2 * LAT)) begin
                n_fail++; $display("FAIL b2b_done c%0d: got %b want %b", k, done_o, k == LAT || k == 2 * LAT);
            end
            if (k == LAT) begin
                n_checks++;
                if (state_o !== EXP_A) begin n_fail++; $display("FAIL b2b_first: got %h want %h", state_o, EXP_A); end
            end
            if (k == 2 * LAT) begin
                n_checks++;
                if (state_o !== EXP_B) begin n_fail++; $display("FAIL b2b_second: got %h want %h", state_o, EXP_B); end
                start_i = 1'b0;
            end
        end
        @(negedge clk);
        n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b want 1", ready_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL b2b_busy: got %b want 0", busy_o); end
    endtask

    task automatic test_start_during_run();
        int dones;
        int done_at;
        dones   = 0;
        done_at = -1;
        start_op(VEC_A);
        for (int k = 1; k <= 2 * LAT + 4; k++) begin
            @(negedge clk);
            if (done_o === 1'b1) begin
                dones++;
                if (done_at < 0) done_at = k;
            end
            if (k == MID) begin
                state_i = VEC_B;
                start_i = 1'b1;
            end
            if (k == MID + 1) start_i = 1'b0;
        end
        n_checks++; if (dones !== 1) begin n_fail++; $display("FAIL run_start_count: got %0d want 1", dones); end
        n_checks++; if (done_at !== LAT) begin n_fail++; $display("FAIL run_start_lat: got %0d want %0d", done_at, LAT); end
        n_checks++; if (state_o !== EXP_A) begin n_fail++; $display("FAIL run_start_result: got %h want %h", state_o, EXP_A); end
    endtask

    task automatic test_reset_mid();
        int done_at;
        done_at = -1;
        start_op(VEC_B);
        for (int k = 1; k < RST_AT; k++) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++; if (state_o !== 128'h0) begin n_fail++; $display("FAIL rstmid_state: got %h want 0", state_o); end
            n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", ready_o); end
            n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy_o); end
        end
        rst_n = 1'b1;
        for (int k = 0; k < 2 * LAT; k++) begin
            @(negedge clk);
            n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_nodone: got %b want 0", done_o); end
            n_checks++; if (state_o !== 128'h0) begin n_fail++; $display("FAIL rstmid_hold: got %h want 0", state_o); end
        end
        start_op(VEC_B);
        for (int k = 1; k <= 3 * LAT; k++) begin
            @(negedge clk);
            if (done_o === 1'b1 && done_at < 0) begin
                done_at = k;
                break;
            end
        end
        n_checks++; if (done_at !== LAT) begin n_fail++; $display("FAIL rstmid_lat: got %0d want %0d", done_at, LAT); end
        n_checks++; if (state_o !== EXP_B) begin n_fail++; $display("FAIL rstmid_result: got %h want %h", state_o, EXP_B); end
    endtask

    task automatic test_hold();
        start_i = 1'b0;
        state_i = VEC_A;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            n_checks++; if (state_o !== EXP_B) begin n_fail++; $display("FAIL hold_state c%0d: got %h want %h", k, state_o, EXP_B); end
            n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL hold_done c%0d: got %b want 0", k, done_o); end
            n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL hold_ready c%0d: got %b want 1", k, ready_o); end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_fips();
        test_back_to_back();
        test_start_during_run();
        test_reset_mid();
        test_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
